cov_frame_scheduler: RTL

Sequencer that sits in front of and behind the covariance engine (N-element, I/Q, PE-array covariance top).
- Front side: arms the engine, gates the sample stream so exactly SAMPLES_NUM snapshots enter per frame, and supervises completion with a timeout.
- Back side: latches the packed diagonal/upper-triangle results and streams the full Hermitian N x N matrix, row-major, over a valid/ready interface to the eigen-decomposition stage.
- Runs single-shot or continuous frames.

---
 rtl/cov_sched_pkg.sv | 30 +++
 rtl/cov_frame_scheduler_if.sv | 26 ++
 rtl/cov_hermitian_reader.sv | 111 +++++++++++
 rtl/cov_frame_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cov_sched_pkg.sv
// Shared types and helpers for the covariance frame scheduler.
package cov_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_ACQ       = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_LATCH     = 3'd4,
        S_STREAM    = 3'd5
    } state_t;

    localparam int unsigned SAT_W = 64;

    // Index of (r,c), c > r, in the row-major packed upper triangle of an n x n matrix.
    function automatic int unsigned upper_idx(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned n);
        return (r * (2 * n - r - 1)) / 2 + (c - r - 1);
    endfunction

    // Two's-complement negate of a w-bit value (sign-extended to SAT_W); -min maps to +max.
    function automatic logic signed [SAT_W-1:0] sat_neg(input logic signed [SAT_W-1:0] x,
                                                        input int unsigned             w);
        logic signed [SAT_W-1:0] min_v;
        min_v = -(64'sd1 <<< (w - 32'd1));
        return (x == min_v) ? (-x - 64'sd1) : -x;
    endfunction

endpackage

// File: rtl/cov_frame_scheduler_if.sv
// Valid/ready stream carrying one Hermitian matrix element per beat.
interface cov_frame_scheduler_if #(
    parameter int unsigned N         = 4,
    parameter int unsigned ACC_WIDTH = 20
);
    localparam int unsigned RC_W = (N > 1) ? $clog2(N) : 1;

    logic                        om_valid;
    logic                        om_ready;
    logic signed [ACC_WIDTH-1:0] om_re;
    logic signed [ACC_WIDTH-1:0] om_im;
    logic [RC_W-1:0]             om_row;
    logic [RC_W-1:0]             om_col;
    logic                        om_last;

    modport master (
        output om_valid, om_re, om_im, om_row, om_col, om_last,
        input  om_ready
    );

    modport slave (
        input  om_valid, om_re, om_im, om_row, om_col, om_last,
        output om_ready
    );

endinterface

// File: rtl/cov_hermitian_reader.sv
// Latches packed diagonal/upper-triangle results and streams the full Hermitian matrix row-major.
module cov_hermitian_reader
    import cov_sched_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic                                iclk,
    input  logic                                irst_n,
    input  logic                                i_load,
    input  logic [ACC_WIDTH*N-1:0]              i_diag,
    input  logic [ACC_WIDTH*(N*(N-1)/2)-1:0]    i_upper_re,
    input  logic [ACC_WIDTH*(N*(N-1)/2)-1:0]    i_upper_im,
    cov_frame_scheduler_if.master               m_if
);

    localparam int unsigned NUP  = N * (N - 1) / 2;
    localparam int unsigned RC_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned K_W  = (NUP > 1) ? $clog2(NUP) : 1;

    logic signed [ACC_WIDTH-1:0] r_diag [N];
    logic signed [ACC_WIDTH-1:0] r_ure  [NUP];
    logic signed [ACC_WIDTH-1:0] r_uim  [NUP];

    logic                        r_valid;
    logic [RC_W-1:0]             r_row;
    logic [RC_W-1:0]             r_col;
    logic signed [ACC_WIDTH-1:0] r_re;
    logic signed [ACC_WIDTH-1:0] r_im;
    logic                        r_last;

    logic [RC_W-1:0]             w_nr;
    logic [RC_W-1:0]             w_nc;
    int unsigned                 w_k;
    logic signed [ACC_WIDTH-1:0] w_re;
    logic signed [ACC_WIDTH-1:0] w_im;
    logic                        w_last;

    // Next element in row-major order, mirrored from the upper triangle below the diagonal.
    always_comb begin
        w_nr = r_row;
        w_nc = r_col + RC_W'(1);
        if (r_col == RC_W'(N - 1)) begin
            w_nc = '0;
            w_nr = r_row + RC_W'(1);
        end
        w_k  = 0;
        w_re = '0;
        w_im = '0;
        if (w_nr == w_nc) begin
            w_re = r_diag[w_nr];
        end else if (w_nc > w_nr) begin
            w_k  = upper_idx(32'(w_nr), 32'(w_nc), N);
            w_re = r_ure[K_W'(w_k)];
            w_im = r_uim[K_W'(w_k)];
        end else begin
            w_k  = upper_idx(32'(w_nc), 32'(w_nr), N);
            w_re = r_ure[K_W'(w_k)];
            w_im = ACC_WIDTH'(sat_neg(SAT_W'(r_uim[K_W'(w_k)]), ACC_WIDTH));
        end
        w_last = (w_nr == RC_W'(N - 1)) && (w_nc == RC_W'(N - 1));
    end

    // Element (0,0) is taken straight from the inputs so the first beat follows the load edge.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            for (int i = 0; i < N; i++) r_diag[i] <= '0;
            for (int i = 0; i < NUP; i++) begin
                r_ure[i] <= '0;
                r_uim[i] <= '0;
            end
            r_valid <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            for (int i = 0; i < N; i++) r_diag[i] <= i_diag[i*ACC_WIDTH +: ACC_WIDTH];
            for (int i = 0; i < NUP; i++) begin
                r_ure[i] <= i_upper_re[i*ACC_WIDTH +: ACC_WIDTH];
                r_uim[i] <= i_upper_im[i*ACC_WIDTH +: ACC_WIDTH];
            end
            r_valid <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_re    <= i_diag[ACC_WIDTH-1:0];
            r_im    <= '0;
            r_last  <= (N == 1);
        end else if (r_valid && m_if.om_ready) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_row  <= w_nr;
                r_col  <= w_nc;
                r_re   <= w_re;
                r_im   <= w_im;
                r_last <= w_last;
            end
        end
    end

    assign m_if.om_valid = r_valid;
    assign m_if.om_re    = r_re;
    assign m_if.om_im    = r_im;
    assign m_if.om_row   = r_row;
    assign m_if.om_col   = r_col;
    assign m_if.om_last  = r_last;

endmodule

// File: rtl/cov_frame_scheduler.sv
// Frame sequencer around the covariance engine: arm, gate samples, supervise done, stream results.
module cov_frame_scheduler
    import cov_sched_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned ACC_WIDTH      = 20,
    parameter int unsigned SAMPLES_NUM    = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                              iclk,
    input  logic                              irst_n,
    input  logic                              ienable,
    input  logic                              itrig,
    input  logic                              isample_valid,
    output logic                              ocov_start,
    output logic                              ocov_data_valid,
    input  logic                              icov_done,
    input  logic [ACC_WIDTH*N-1:0]            icov_diag,
    input  logic [ACC_WIDTH*(N*(N-1)/2)-1:0]  icov_upper_re,
    input  logic [ACC_WIDTH*(N*(N-1)/2)-1:0]  icov_upper_im,
    cov_frame_scheduler_if.master             m_if,
    output logic                              obusy,
    output logic                              oerror,
    output logic [15:0]                       oframe_cnt
);

    localparam int unsigned CNT_W  = $clog2(SAMPLES_NUM + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            r_state;
    logic              r_start;
    logic              r_busy;
    logic              r_err;
    logic [15:0]       r_frame;
    logic [CNT_W-1:0]  r_scnt;
    logic [TCNT_W-1:0] r_tcnt;

    logic              w_load;
    logic              w_last_hs;

    assign w_load    = (r_state == S_LATCH);
    assign w_last_hs = m_if.om_valid & m_if.om_ready & m_if.om_last;

    // Sample gate is deliberately combinational so gaps in the source cost no latency.
    assign ocov_data_valid = (r_state == S_ACQ) & isample_valid;

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_frame <= '0;
            r_scnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (itrig || ienable) begin
                        r_state <= S_ARM;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_state <= S_ACQ;
                    r_scnt  <= '0;
                end
                S_ACQ: begin
                    if (isample_valid) begin
                        r_scnt <= r_scnt + CNT_W'(1);
                        if (r_scnt == CNT_W'(SAMPLES_NUM - 1)) begin
                            r_state <= S_WAIT_DONE;
                            r_tcnt  <= '0;
                        end
                    end
                end
                // Done has priority over a coincident timeout.
                S_WAIT_DONE: begin
                    if (icov_done) begin
                        r_state <= S_LATCH;
                    end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_LATCH: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_last_hs) begin
                        r_frame <= r_frame + 16'd1;
                        if (ienable) begin
                            r_state <= S_ARM;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    cov_hermitian_reader #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_reader (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .i_load     (w_load),
        .i_diag     (icov_diag),
        .i_upper_re (icov_upper_re),
        .i_upper_im (icov_upper_im),
        .m_if       (m_if)
    );

    assign ocov_start = r_start;
    assign obusy      = r_busy;
    assign oerror     = r_err;
    assign oframe_cnt = r_frame;

endmodule
